// File: rtl/key_event_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_if
//  Description : Valid/ready event channel carrying a 2-bit key event code
//                from the key event generator to its consumer.
//  Revision    : 1.0  initial release
// ============================================================================
interface key_event_if;
    logic       event_valid;
    logic [1:0] event_code;
    logic       event_ready;

    // Producer side: owns valid and code, observes ready.
    modport master (
        output event_valid,
        output event_code,
        input  event_ready
    );

    // Consumer side: observes valid and code, owns ready.
    modport slave (
        input  event_valid,
        input  event_code,
        output event_ready
    );
endinterface
`default_nettype wire

// File: rtl/key_event.sv
`default_nettype none
// ============================================================================
//  Module      : key_event
//  Description : Turns a debounced key level into PRESS / RELEASE / LONG /
//                REPEAT events, paced by a free-running prescaler tick and
//                delivered through a one-deep valid/ready buffer with a
//                sticky overflow flag for dropped events.
//  Revision    : 1.0  initial release
// ============================================================================
module key_event #(
    parameter int PRESCALE_WIDTH = 16,
    parameter int LONG_TICKS     = 100,
    parameter int REPEAT_TICKS   = 20
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   in,
    key_event_if.master evt,
    output logic        pressed,
    output logic        overflow
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_HOLD   = 2'd1;
    localparam logic [1:0] c_S_REPEAT = 2'd2;

    localparam logic [1:0] c_EV_PRESS   = 2'd0;
    localparam logic [1:0] c_EV_RELEASE = 2'd1;
    localparam logic [1:0] c_EV_LONG    = 2'd2;
    localparam logic [1:0] c_EV_REPEAT  = 2'd3;

    localparam logic [15:0] c_LONG_TICKS   = 16'(LONG_TICKS);
    localparam logic [15:0] c_REPEAT_TICKS = 16'(REPEAT_TICKS);
    localparam logic        c_REPEAT_EN    = (REPEAT_TICKS != 0);

    logic [PRESCALE_WIDTH-1:0] r_presc;
    logic                      r_in_q;
    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic [15:0]               r_cnt;
    logic [15:0]               w_cnt_nxt;
    logic [15:0]               w_cnt_inc;
    logic                      w_tick;
    logic                      w_rise;
    logic                      w_fall;
    logic                      w_emit;
    logic [1:0]                w_code;
    logic                      r_valid;
    logic [1:0]                r_code;
    logic                      r_overflow;

    assign w_tick    = &r_presc;
    assign w_rise    = in & ~r_in_q;
    assign w_fall    = ~in & r_in_q;
    assign w_cnt_inc = r_cnt + 16'd1;

    // Free-running prescaler and registered key level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_in_q  <= 1'b0;
        end else begin
            r_presc <= r_presc + PRESCALE_WIDTH'(1);
            r_in_q  <= in;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; an edge always takes priority over a tick.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_rise) w_state_nxt = c_S_HOLD;
            end
            c_S_HOLD: begin
                if (w_fall) begin
                    w_state_nxt = c_S_IDLE;
                end else if (w_tick && (w_cnt_inc == c_LONG_TICKS)) begin
                    w_state_nxt = c_S_REPEAT;
                end
            end
            c_S_REPEAT: begin
                if (w_fall) w_state_nxt = c_S_IDLE;
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // Output decode: event emission and the next hold count.
    always_comb begin
        w_emit    = 1'b0;
        w_code    = c_EV_PRESS;
        w_cnt_nxt = r_cnt;
        case (r_state)
            c_S_IDLE: begin
                if (w_rise) begin
                    w_emit    = 1'b1;
                    w_code    = c_EV_PRESS;
                    w_cnt_nxt = 16'd0;
                end
            end
            c_S_HOLD: begin
                if (w_fall) begin
                    w_emit = 1'b1;
                    w_code = c_EV_RELEASE;
                end else if (w_tick) begin
                    if (w_cnt_inc == c_LONG_TICKS) begin
                        w_emit    = 1'b1;
                        w_code    = c_EV_LONG;
                        w_cnt_nxt = 16'd0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            c_S_REPEAT: begin
                if (w_fall) begin
                    w_emit = 1'b1;
                    w_code = c_EV_RELEASE;
                end else if (c_REPEAT_EN && w_tick) begin
                    if (w_cnt_inc == c_REPEAT_TICKS) begin
                        w_emit    = 1'b1;
                        w_code    = c_EV_REPEAT;
                        w_cnt_nxt = 16'd0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            default: w_cnt_nxt = 16'd0;
        endcase
    end

    // Hold counter; clears at each threshold so it never needs to saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // One-deep event buffer: a full buffer with a stalled consumer drops the
    // new event and leaves the held code untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_code     <= 2'd0;
            r_overflow <= 1'b0;
        end else if (w_emit) begin
            if (!r_valid || evt.event_ready) begin
                r_valid <= 1'b1;
                r_code  <= w_code;
            end else begin
                r_overflow <= 1'b1;
            end
        end else if (r_valid && evt.event_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign evt.event_valid = r_valid;
    assign evt.event_code  = r_code;
    assign pressed         = r_in_q;
    assign overflow        = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_key_event.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_event
//  Description : Directed self-checking bench for key_event. Two instances
//                share stimulus: one with repeat enabled, one with repeat
//                disabled. Cycle numbers count rising edges since the last
//                reset release, so prescaler phase is known exactly.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_event;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic in    = 1'b0;
    logic ready = 1'b1;

    logic pressed_a, overflow_a, pressed_b, overflow_b;

    key_event_if evt_a ();
    key_event_if evt_b ();

    assign evt_a.event_ready = ready;
    assign evt_b.event_ready = ready;

    always #5 clk = ~clk;

    key_event #(.PRESCALE_WIDTH(2), .LONG_TICKS(3), .REPEAT_TICKS(2)) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .evt      (evt_a),
        .pressed  (pressed_a),
        .overflow (overflow_a)
    );

    key_event #(.PRESCALE_WIDTH(2), .LONG_TICKS(3), .REPEAT_TICKS(0)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .evt      (evt_b),
        .pressed  (pressed_b),
        .overflow (overflow_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    int log_a_cyc[$];
    int log_a_code[$];
    int log_b_cyc[$];
    int log_b_code[$];
    int exp_cyc[$];
    int exp_code[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clocks; sample #1 after each edge and log consumed events.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (evt_a.event_valid && ready) begin
                log_a_cyc.push_back(cyc);
                log_a_code.push_back(int'(evt_a.event_code));
            end
            if (evt_b.event_valid && ready) begin
                log_b_cyc.push_back(cyc);
                log_b_code.push_back(int'(evt_b.event_code));
            end
        end
    endtask

    task automatic clear_logs();
        log_a_cyc.delete();
        log_a_code.delete();
        log_b_cyc.delete();
        log_b_code.delete();
        exp_cyc.delete();
        exp_code.delete();
    endtask

    // Reset for two clocks; release just after an edge so the next edge is 1.
    task automatic do_reset();
        ready = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        clear_logs();
    endtask

    task automatic expect_ev(input int c, input int k);
        exp_cyc.push_back(c);
        exp_code.push_back(k);
    endtask

    task automatic compare_log(input string tag, input bit use_b);
        int n_obs;
        n_obs = use_b ? log_b_cyc.size() : log_a_cyc.size();
        check_val({tag, "_count"}, n_obs, exp_cyc.size());
        for (int i = 0; i < exp_cyc.size() && i < n_obs; i++) begin
            check_val($sformatf("%s_cyc%0d", tag, i),
                      use_b ? log_b_cyc[i] : log_a_cyc[i], exp_cyc[i]);
            check_val($sformatf("%s_code%0d", tag, i),
                      use_b ? log_b_code[i] : log_a_code[i], exp_code[i]);
        end
        exp_cyc.delete();
        exp_code.delete();
    endtask

    initial begin
        // Power-on reset values.
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_valid", evt_a.event_valid, 0);
        check_val("rst_code", evt_a.event_code, 0);
        check_val("rst_pressed", pressed_a, 0);
        check_val("rst_overflow", overflow_a, 0);

        // Short press and release: no LONG.
        do_reset();
        step(2);
        in = 1'b1;
        step(1);
        check_val("pr_valid", evt_a.event_valid, 1);
        check_val("pr_code", evt_a.event_code, 0);
        check_val("pr_pressed", pressed_a, 1);
        step(4);
        in = 1'b0;
        step(1);
        check_val("rel_valid", evt_a.event_valid, 1);
        check_val("rel_code", evt_a.event_code, 1);
        step(4);
        expect_ev(3, 0);
        expect_ev(8, 1);
        compare_log("short", 1'b0);

        // Long hold: LONG then REPEAT every 8 clocks; repeat-disabled instance
        // only sees PRESS, LONG, RELEASE.
        do_reset();
        in = 1'b1;
        step(40);
        in = 1'b0;
        step(6);
        expect_ev(1, 0);
        expect_ev(12, 2);
        expect_ev(20, 3);
        expect_ev(28, 3);
        expect_ev(36, 3);
        expect_ev(41, 1);
        compare_log("long_a", 1'b0);
        expect_ev(1, 0);
        expect_ev(12, 2);
        expect_ev(41, 1);
        compare_log("long_b", 1'b1);
        check_val("long_ovf", overflow_a, 0);

        // Stalled consumer: RELEASE dropped, overflow sticky.
        do_reset();
        ready = 1'b0;
        in    = 1'b1;
        step(1);
        check_val("st_valid1", evt_a.event_valid, 1);
        check_val("st_code1", evt_a.event_code, 0);
        step(1);
        in = 1'b0;
        step(1);
        check_val("st_valid2", evt_a.event_valid, 1);
        check_val("st_code2", evt_a.event_code, 0);
        check_val("st_ovf2", overflow_a, 1);
        check_val("st_pressed", pressed_a, 0);
        step(2);
        check_val("st_code3", evt_a.event_code, 0);
        ready = 1'b1;
        step(1);
        check_val("st_valid4", evt_a.event_valid, 0);
        check_val("st_ovf4", overflow_a, 1);

        // Consume and load on the same edge.
        do_reset();
        ready = 1'b0;
        in    = 1'b1;
        step(1);
        check_val("cl_code1", evt_a.event_code, 0);
        step(1);
        in    = 1'b0;
        ready = 1'b1;
        step(1);
        check_val("cl_valid", evt_a.event_valid, 1);
        check_val("cl_code", evt_a.event_code, 1);
        check_val("cl_ovf", overflow_a, 0);
        step(1);
        check_val("cl_valid2", evt_a.event_valid, 0);

        // Reset mid-hold while in REPEAT, key still held.
        do_reset();
        in = 1'b1;
        step(15);
        check_val("mr_pressed_pre", pressed_a, 1);
        rst_n = 1'b0;
        #1;
        check_val("mr_valid", evt_a.event_valid, 0);
        check_val("mr_code", evt_a.event_code, 0);
        check_val("mr_pressed", pressed_a, 0);
        check_val("mr_ovf", overflow_a, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        clear_logs();
        step(14);
        expect_ev(1, 0);
        expect_ev(12, 2);
        compare_log("mr", 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_event.md
# key_event

Converts one debounced key level into discrete press, release, long-press and auto-repeat events, delivered through a one-deep valid/ready buffer. It sits directly downstream of the chattering-removal stage, at the consuming end of the debounced button signal, and feeds control logic such as the register-file test front end. A shared free-running prescaler provides the time base, and the default sample rate matches the debouncer.

## Interface
- PrescaleWidth, 16: width of the free-running prescaler; one tick every 2^PrescaleWidth clocks.
- LongTicks, 100: ticks of continuous hold before LONG; legal range 1..65535.
- RepeatTicks, 20: ticks between REPEAT events after LONG; 0 disables repeat.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in  in  1  debounced key level, 1 = pressed; already synchronous to clk.
- event_valid  out  1  buffer holds an event.
- event_code  out  2  0 = PRESS, 1 = RELEASE, 2 = LONG, 3 = REPEAT; meaningful only while event_valid = 1.
- event_ready  in  1  consumer accepts the event on an edge where event_valid = 1.
- pressed  out  1  registered key level (in_q).
- overflow  out  1  sticky flag: an event was dropped.

## Operation
- **Reset:** rst_n low clears the following asynchronously:
  - prescaler = 0, in_q = 0, hold count = 0, state = IDLE
  - event_valid = 0, event_code = 0, pressed = 0, overflow = 0
- **Tick:** the prescaler increments every clock and wraps. tick = 1 in cycles where prescaler = 2^PrescaleWidth-1.
- **Edge detection:** in_q <= in every edge.
  - Rise: in = 1 and in_q = 0.
  - Fall: in = 0 and in_q = 1.
- **State IDLE:**
  - Rise: emit PRESS, clear the count, go to HOLD.
- **State HOLD:**
  - Fall: emit RELEASE, go to IDLE.
  - Otherwise, on tick: count + 1. When count + 1 = LongTicks, emit LONG, clear the count and go to REPEAT.
- **State REPEAT:**
  - Fall: emit RELEASE, go to IDLE.
  - Otherwise, if RepeatTicks ≠ 0, on tick: count + 1. When count + 1 = RepeatTicks, emit REPEAT and clear the count.
- **Edge and tick together:** the edge wins.
  - On a rise, the count clears and that tick is not counted.
  - On a fall, the tick is ignored.
- **Count width:** the hold count is 16 bits, compared at full width, and never saturates because it clears at each threshold.
- **Buffer behaviour on emit:**
  - Empty: load the code and set event_valid.
  - Full and event_ready = 1 on the same edge: the old event is consumed and the new one loaded (event_valid stays 1).
  - Full and event_ready = 0: drop the new event and set overflow. The held event is unchanged.
- **Buffer with no emit:** event_valid && event_ready clears event_valid.
- **event_code stability:** event_code must not change while event_valid = 1 and event_ready = 0.
- **overflow:** cleared only by reset.
- **Key held through reset:** after rst_n is released, in_q = 0, so the first edge produces PRESS.

## Timing
- PRESS and RELEASE appear on event_valid/event_code at the same edge at which in_q takes the new value, i.e. one clock after in changes.
- **LONG:** asserted at the edge ending the LongTicks-th tick cycle after the press edge. Latency from the press edge is between (LongTicks-1)·2^PrescaleWidth+1 and LongTicks·2^PrescaleWidth clocks, depending on prescaler phase.
- **REPEAT:** exactly RepeatTicks·2^PrescaleWidth clocks apart, with the first one that far after LONG.
- **Prescaler phase:** the first tick after rst_n deasserts is at the 2^PrescaleWidth-th rising edge.
- **Throughput:** one event per clock when event_ready is held at 1.
- **Reset mid-operation:** the pending event and the state are lost, and no RELEASE is generated.

## Test plan
Parameters for all scenarios: PrescaleWidth = 2, LongTicks = 3, RepeatTicks = 2, event_ready = 1 unless stated.

- **Press/release:** in rises, held 5 clocks, falls.
  - event_valid for one clock with code 0 one clock after the rise.
  - Later event_valid for one clock with code 1 one clock after the fall.
  - No LONG.
- **Long press and repeat:** in held high for 40 clocks.
  - PRESS, then LONG 9..12 clocks later.
  - REPEAT every 8 clocks until the fall, then RELEASE.
  - overflow = 0 throughout.
- **Stalled consumer:** event_ready = 0, press then release.
  - PRESS held with code 0 stable.
  - RELEASE dropped and overflow = 1.
  - Raising event_ready consumes PRESS, and overflow stays 1.
- **Consume and load on the same edge:** PRESS pending with event_ready = 0. Raise event_ready at the same edge the fall is detected.
  - event_valid stays 1 and the code changes 0 -> 1.
  - overflow = 0.
- **RepeatTicks = 0:** hold 40 clocks.
  - Exactly PRESS, LONG, RELEASE.
- **Reset mid-hold:** pulse rst_n low for 1 clock during REPEAT with in held high.
  - All outputs 0 during reset.
  - PRESS one clock after rst_n rises.
  - LONG after a fresh 9..12 clocks.
